ht_probe_table: RTL

- Parametrised open-addressing key/value hash table with linear probing, one slot examined per clock.
- Supported operations: LOOKUP, INSERT (upsert), DELETE (tombstone) and CLEAR.
- Next-generation storage engine behind the chip-level command front end, replacing the fixed 4-bit key / 8-slot table.
- Adds generic widths and depth, delete with tombstones, a valid/ready request handshake and a pulsed response.

---
 rtl/ht_pkg.sv | 27 ++
 rtl/ht_hash.sv | 26 ++
 rtl/ht_probe_table.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ht_pkg.sv
// Shared encodings for the open-addressing hash table: commands, statuses,
// per-slot state and controller state.
// Pure declarations; no logic, no latency, no flow control.
package ht_pkg;

    localparam logic [1:0] HT_CMD_LOOKUP = 2'd0;
    localparam logic [1:0] HT_CMD_INSERT = 2'd1;
    localparam logic [1:0] HT_CMD_DELETE = 2'd2;
    localparam logic [1:0] HT_CMD_CLEAR  = 2'd3;

    localparam logic [1:0] HT_ST_OK        = 2'd0;
    localparam logic [1:0] HT_ST_NOT_FOUND = 2'd1;
    localparam logic [1:0] HT_ST_FULL      = 2'd2;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_LIVE  = 2'd1,
        SLOT_TOMB  = 2'd2
    } slot_state_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_RESP  = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/ht_hash.sv
// Folds a key into a table index by XOR of IDX_W-bit chunks, LSB chunk first.
// Purely combinational, zero latency.
// No flow control; the top-level table owns all handshaking.
module ht_hash #(
    parameter int KEY_W = 8,
    parameter int IDX_W = 3
) (
    input  logic [KEY_W-1:0] key,
    output logic [IDX_W-1:0] idx
);

    localparam int NCH = (KEY_W + IDX_W - 1) / IDX_W;

    logic [NCH*IDX_W-1:0] padded;

    // Zero-pad the top chunk, then XOR-fold every chunk together.
    always_comb begin
        padded = '0;
        padded[KEY_W-1:0] = key;
        idx = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = idx ^ padded[i*IDX_W +: IDX_W];
        end
    end

endmodule

// File: rtl/ht_probe_table.sv
// Linear-probing key/value table: LOOKUP, INSERT (upsert), DELETE (tombstone), CLEAR.
// Latency 2+k cycles from accept to resp_valid (k = terminating probe), worst case DEPTH+1.
// req_ready only in IDLE; resp_valid is a one-cycle pulse with no backpressure. Macro: HT_OCCUPANCY_EN.
module ht_probe_table
    import ht_pkg::*;
#(
    parameter int KEY_W = 8,
    parameter int VAL_W = 8,
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_cmd,
    input  logic [KEY_W-1:0] req_key,
    input  logic [VAL_W-1:0] req_val,
    output logic             resp_valid,
    output logic [1:0]       resp_status,
    output logic [VAL_W-1:0] resp_val,
    output logic [IDX_W:0]   occupancy
);

    fsm_state_e state, state_nxt;

    // Latched request and probe bookkeeping.
    logic [1:0]       cmd_q;
    logic [KEY_W-1:0] key_q;
    logic [VAL_W-1:0] val_q;
    logic [IDX_W-1:0] k_q;
    logic             free_seen_q;
    logic [IDX_W-1:0] free_idx_q;

    // Slot state bits (reset) and payload storage (not reset).
    logic [DEPTH-1:0] live_q;
    logic [DEPTH-1:0] tomb_q;
    logic [KEY_W-1:0] key_mem [DEPTH];
    logic [VAL_W-1:0] val_mem [DEPTH];

    logic [IDX_W-1:0] hash_idx;
    logic [IDX_W-1:0] probe_idx;
    slot_state_e      cur_st;
    logic             accept;
    logic             cur_match;
    logic             last_probe;
    logic             probe_done;
    logic             wr_key_en;
    logic             wr_val_en;
    logic [IDX_W-1:0] wr_idx;
    logic             set_live;
    logic             set_tomb;
    logic             clr_all;
    logic [1:0]       status_nxt;
    logic [VAL_W-1:0] rval_nxt;

    ht_hash #(
        .KEY_W (KEY_W),
        .IDX_W (IDX_W)
    ) u_hash (
        .key (key_q),
        .idx (hash_idx)
    );

    assign accept     = req_valid && req_ready;
    assign probe_idx  = hash_idx + k_q;
    assign last_probe = (k_q == IDX_W'(DEPTH - 1));
    assign cur_match  = live_q[probe_idx] && (key_mem[probe_idx] == key_q);

    // Decode the state of the slot currently under the probe.
    always_comb begin
        cur_st = SLOT_EMPTY;
        if (live_q[probe_idx])      cur_st = SLOT_LIVE;
        else if (tomb_q[probe_idx]) cur_st = SLOT_TOMB;
    end

    // Per-probe decision: does the walk stop here, and what does it write/report.
    always_comb begin
        probe_done = 1'b0;
        wr_key_en  = 1'b0;
        wr_val_en  = 1'b0;
        wr_idx     = probe_idx;
        set_live   = 1'b0;
        set_tomb   = 1'b0;
        clr_all    = 1'b0;
        status_nxt = HT_ST_NOT_FOUND;
        rval_nxt   = '0;
        if (state == ST_PROBE) begin
            // A hit, an EMPTY slot or the last probe ends every keyed walk.
            probe_done = cur_match || (cur_st == SLOT_EMPTY) || last_probe;
            case (cmd_q)
                HT_CMD_LOOKUP: begin
                    if (cur_match) begin
                        status_nxt = HT_ST_OK;
                        rval_nxt   = val_mem[probe_idx];
                    end
                end
                HT_CMD_INSERT: begin
                    if (cur_match) begin
                        wr_val_en  = probe_done;
                        status_nxt = HT_ST_OK;
                    end else if (free_seen_q || (cur_st != SLOT_LIVE)) begin
                        // Reuse the earliest free slot so lookups stop as soon as possible.
                        wr_idx     = free_seen_q ? free_idx_q : probe_idx;
                        wr_key_en  = probe_done;
                        wr_val_en  = probe_done;
                        set_live   = probe_done;
                        status_nxt = HT_ST_OK;
                    end else begin
                        status_nxt = HT_ST_FULL;
                    end
                end
                HT_CMD_DELETE: begin
                    if (cur_match) begin
                        set_tomb   = 1'b1;
                        status_nxt = HT_ST_OK;
                    end
                end
                default: begin
                    probe_done = 1'b1;
                    clr_all    = 1'b1;
                    status_nxt = HT_ST_OK;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_PROBE;
            ST_PROBE: if (probe_done) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: ready only when idle, response pulse for the single RESP cycle.
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
    end

    // Request latch, probe counter, first-free-slot tracker and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= HT_CMD_LOOKUP;
            key_q       <= '0;
            val_q       <= '0;
            k_q         <= '0;
            free_seen_q <= 1'b0;
            free_idx_q  <= '0;
            resp_status <= HT_ST_OK;
            resp_val    <= '0;
        end else begin
            if (accept) begin
                cmd_q       <= req_cmd;
                key_q       <= req_key;
                val_q       <= req_val;
                k_q         <= '0;
                free_seen_q <= 1'b0;
            end
            if (state == ST_PROBE) begin
                if (probe_done) begin
                    resp_status <= status_nxt;
                    resp_val    <= rval_nxt;
                end else begin
                    k_q <= k_q + IDX_W'(1);
                    if (!free_seen_q && (cur_st != SLOT_LIVE)) begin
                        free_seen_q <= 1'b1;
                        free_idx_q  <= probe_idx;
                    end
                end
            end
        end
    end

    // Slot state bits; CLEAR empties every slot at once.
    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            live_q <= '0;
            tomb_q <= '0;
        end else if (set_live) begin
            live_q[wr_idx] <= 1'b1;
            tomb_q[wr_idx] <= 1'b0;
        end else if (set_tomb) begin
            live_q[wr_idx] <= 1'b0;
            tomb_q[wr_idx] <= 1'b1;
        end
    end

    // Key/value payload; meaningless unless the slot is LIVE, so it is never reset.
    always_ff @(posedge clk) begin
        if (wr_key_en) key_mem[wr_idx] <= key_q;
        if (wr_val_en) val_mem[wr_idx] <= val_q;
    end

`ifdef HT_OCCUPANCY_EN
    logic [IDX_W:0] occ_q;

    // Live-entry counter; inserts only land in free slots so it cannot pass DEPTH.
    always_ff @(posedge clk) begin
        if (rst || clr_all) occ_q <= '0;
        else if (set_live)  occ_q <= occ_q + (IDX_W+1)'(1);
        else if (set_tomb)  occ_q <= occ_q - (IDX_W+1)'(1);
    end

    assign occupancy = occ_q;
`else
    assign occupancy = '0;
`endif

endmodule
